serial_add_seq: RTL and testbench

Bit-serial adder sequencer. Accepts two WIDTH-bit operands and a carry-in, presents them one bit per clock (LSB first) to an external gate-level 1-bit full adder (`addbit`), and recirculates that adder's carry-out. It collects the sum bits into a WIDTH-bit result and reports completion with a one-cycle `done` pulse. The block sits directly upstream of the `addbit` instance, drives all three of its inputs, and consumes both of its outputs.

---
 rtl/serial_add_seq.sv | 103 ++++++++++
 tb/tb_serial_add_seq.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_add_seq.sv
// Bit-serial adder sequencer: feeds an external 1-bit full adder LSB first
// and recirculates its carry into a WIDTH-bit sum.
module serial_add_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             bit_a,
  output logic             bit_b,
  output logic             bit_ci,
  input  logic             bit_sum,
  input  logic             bit_co
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SHIFT;
          a_d     = op_a;
          b_d     = op_b;
          carry_d = cin;
          cnt_d   = '0;
        end
      end
      SHIFT: begin
        res_d   = {bit_sum, res_q[WIDTH-1:1]};
        carry_d = bit_co;
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        // hold the counter on the last bit so it never wraps
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
    end
  end

  // adder inputs come straight from flops
  assign bit_a  = a_q[0];
  assign bit_b  = b_q[0];
  assign bit_ci = carry_q;
  assign busy   = (state_q == SHIFT);
  assign done   = (state_q == DONE);
  assign result = res_q;
  assign cout   = carry_q;

endmodule

// File: tb/tb_serial_add_seq.sv
// Bench for serial_add_seq: WIDTH=8 and WIDTH=16 instances, each driving
// a behavioural full adder; directed vectors plus a sum-level model.
module tb_serial_add_seq;

  logic clk = 1'b0;
  logic rst = 1'b0;

  logic       start8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       cin8 = 1'b0;
  logic       busy8, done8, cout8;
  logic [7:0] res8;
  logic       ba8, bb8, bc8, s8, co8;

  logic        start16 = 1'b0;
  logic [15:0] a16 = '0, b16 = '0;
  logic        cin16 = 1'b0;
  logic        busy16, done16, cout16;
  logic [15:0] res16;
  logic        ba16, bb16, bc16, s16, co16;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  assign s8   = ba8 ^ bb8 ^ bc8;
  assign co8  = (ba8 & bb8) | (ba8 & bc8) | (bb8 & bc8);
  assign s16  = ba16 ^ bb16 ^ bc16;
  assign co16 = (ba16 & bb16) | (ba16 & bc16) | (bb16 & bc16);

  serial_add_seq #(.WIDTH(8)) u8 (
    .clk(clk), .rst(rst), .start(start8),
    .op_a(a8), .op_b(b8), .cin(cin8),
    .busy(busy8), .done(done8),
    .result(res8), .cout(cout8),
    .bit_a(ba8), .bit_b(bb8), .bit_ci(bc8),
    .bit_sum(s8), .bit_co(co8)
  );

  serial_add_seq #(.WIDTH(16)) u16 (
    .clk(clk), .rst(rst), .start(start16),
    .op_a(a16), .op_b(b16), .cin(cin16),
    .busy(busy16), .done(done16),
    .result(res16), .cout(cout16),
    .bit_a(ba16), .bit_b(bb16), .bit_ci(bc16),
    .bit_sum(s16), .bit_co(co16)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model of the 8-bit instance: operation timeline in cycles since
  // the accepting edge, sum and per-bit carries from plain arithmetic.
  int         m_phase = 0;
  logic [7:0] m_a = '0, m_b = '0, m_res = '0;
  logic       m_cin = 1'b0, m_cout = 1'b0;
  logic [8:0] m_sum = '0;
  int         m_k, m_mask, m_part;

  always begin
    @(posedge clk);
    if (rst) begin
      m_phase = 0;
      m_res   = '0;
      m_cout  = 1'b0;
    end else if (m_phase == 0) begin
      if (start8 === 1'b1) begin
        m_a     = a8;
        m_b     = b8;
        m_cin   = cin8;
        m_sum   = 9'(a8) + 9'(b8) + 9'(cin8);
        m_phase = 1;
      end
    end else if (m_phase == 9) begin
      m_phase = 0;
    end else begin
      m_phase++;
      if (m_phase == 9) {m_cout, m_res} = m_sum;
    end
    @(negedge clk);
    if (rst) begin
      chk("rst_busy", busy8, 0);
      chk("rst_done", done8, 0);
    end else begin
      chk("m_busy", busy8, (m_phase >= 1 && m_phase <= 8));
      chk("m_done", done8, (m_phase == 9));
      if (m_phase == 0 || m_phase == 9) begin
        chk("m_result", res8, m_res);
        chk("m_cout", cout8, m_cout);
      end else begin
        m_k    = m_phase - 1;
        m_mask = (1 << m_k) - 1;
        m_part = (int'(m_a) & m_mask) + (int'(m_b) & m_mask) + int'(m_cin);
        chk("m_bit_a", ba8, m_a[m_k]);
        chk("m_bit_b", bb8, m_b[m_k]);
        chk("m_bit_ci", bc8, (m_part >> m_k) & 1);
      end
    end
  end

  task automatic run8(input logic [7:0] a, input logic [7:0] b,
                      input logic c, input int inj,
                      output int busy_n, output int done_at,
                      output int done_n, output logic [7:0] sa,
                      output logic [7:0] sci);
    @(posedge clk);
    #2;
    start8 = 1'b1;
    a8 = a;
    b8 = b;
    cin8 = c;
    @(posedge clk);
    #2;
    start8 = 1'b0;
    busy_n = 0;
    done_at = -1;
    done_n = 0;
    sa = '0;
    sci = '0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (busy8) begin
        if (busy_n < 8) begin
          sa[busy_n] = ba8;
          sci[busy_n] = bc8;
        end
        busy_n++;
      end
      if (done8) begin
        done_n++;
        if (done_at < 0) done_at = i;
      end
      if (i == inj) begin
        start8 = 1'b1;
        a8 = 8'h11;
      end
      if (i == inj + 1) start8 = 1'b0;
    end
  endtask

  task automatic op8(input string tag, input logic [7:0] a,
                     input logic [7:0] b, input logic c, input int inj,
                     input logic [7:0] exp_r, input logic exp_c,
                     output logic [7:0] sa, output logic [7:0] sci);
    int bn, da, dn;
    run8(a, b, c, inj, bn, da, dn, sa, sci);
    chk({tag, "_busy_cycles"}, bn, 8);
    chk({tag, "_done_edge"}, da, 9);
    chk({tag, "_done_count"}, dn, 1);
    chk({tag, "_result"}, res8, exp_r);
    chk({tag, "_cout"}, cout8, exp_c);
  endtask

  task automatic op16(input logic [15:0] a, input logic [15:0] b,
                      input logic c);
    int bn, da;
    logic [16:0] exp;
    exp = 17'(a) + 17'(b) + 17'(c);
    @(posedge clk);
    #2;
    start16 = 1'b1;
    a16 = a;
    b16 = b;
    cin16 = c;
    @(posedge clk);
    #2;
    start16 = 1'b0;
    bn = 0;
    da = -1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (busy16) bn++;
      if (done16 && da < 0) da = i;
    end
    chk("w16_busy_cycles", bn, 16);
    chk("w16_done_edge", da, 17);
    chk("w16_sum", {cout16, res16}, exp);
  endtask

  initial begin
    logic [7:0] sa, sci;
    logic [7:0] ra, rb;
    logic       rc;
    logic [8:0] rs;
    int         dpos[4];
    int         dn;

    #1 rst = 1'b1;
    #1;
    chk("reset_busy", busy8, 0);
    chk("reset_done", done8, 0);
    chk("reset_result", res8, 0);
    chk("reset_cout", cout8, 0);
    chk("reset_bits", {ba8, bb8, bc8}, 0);
    chk("reset_w16", {busy16, done16, res16, cout16}, 0);
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b0;

    op8("basic", 8'h3C, 8'h42, 1'b0, -1, 8'h7E, 1'b0, sa, sci);
    op8("ripple", 8'hFF, 8'h01, 1'b0, -1, 8'h00, 1'b1, sa, sci);
    chk("ripple_bit_ci_seq", sci, 8'hFE);
    op8("cin", 8'hA5, 8'h5A, 1'b1, -1, 8'h00, 1'b1, sa, sci);
    chk("cin_bit_a_seq", sa, 8'hA5);
    op8("ign_busy", 8'h10, 8'h20, 1'b0, 3, 8'h30, 1'b0, sa, sci);
    op8("after_ign", 8'h80, 8'h80, 1'b1, -1, 8'h01, 1'b1, sa, sci);

    // reset partway: bits 0..3 of 0x0F+0x09 leave result=0x80, carry=1
    @(posedge clk);
    #2;
    start8 = 1'b1;
    a8 = 8'h0F;
    b8 = 8'h09;
    cin8 = 1'b0;
    @(posedge clk);
    #2 start8 = 1'b0;
    repeat (5) @(negedge clk);
    chk("pre_rst_result", res8, 8'h80);
    chk("pre_rst_cout", cout8, 1);
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_busy", busy8, 0);
    chk("mid_rst_done", done8, 0);
    chk("mid_rst_result", res8, 0);
    chk("mid_rst_cout", cout8, 0);
    @(posedge clk);
    #2 rst = 1'b0;
    dn = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done8 || busy8) dn++;
    end
    chk("no_done_after_rst", dn, 0);
    op8("post_rst", 8'h01, 8'h01, 1'b0, -1, 8'h02, 1'b0, sa, sci);

    // start held high: accepts at E0, E10, E20, E30
    @(posedge clk);
    #2;
    start8 = 1'b1;
    a8 = 8'h3C;
    b8 = 8'h42;
    cin8 = 1'b0;
    @(posedge clk);
    dn = 0;
    for (int i = 1; i <= 31; i++) begin
      @(negedge clk);
      if (done8) begin
        if (dn < 4) dpos[dn] = i;
        dn++;
      end
    end
    start8 = 1'b0;
    chk("b2b_done_count", dn, 3);
    chk("b2b_done0", dpos[0], 9);
    chk("b2b_done1", dpos[1], 19);
    chk("b2b_done2", dpos[2], 29);
    repeat (12) @(negedge clk);
    chk("b2b_result", res8, 8'h7E);

    for (int n = 0; n < 1000; n++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      rc = 1'($urandom_range(0, 1));
      rs = 9'(ra) + 9'(rb) + 9'(rc);
      op8("rand8", ra, rb, rc, -1, rs[7:0], rs[8], sa, sci);
      chk("rand8_bit_a_seq", sa, ra);
    end

    op16(16'hFFFF, 16'h0001, 1'b0);
    op16(16'h1234, 16'h8765, 1'b1);
    for (int n = 0; n < 1000; n++) begin
      op16(16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)),
           1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
